fq_ud_pulse_gen: RTL and testbench
==================================

# fq_ud_pulse_gen

Multi-channel DDS frequency-update strobe generator, clocked on the falling edge of clk_100M. Each channel synchronises an fq_ud request and drives a DDS FQ_UD pin. A channel either passes the request through as a delayed copy (legacy mode) or converts each rising edge into a fixed-width pulse with enforced hold-off. Requests that arrive while a pulse is in progress are queued one-deep, and overrun is flagged. It sits between the sequencer/SPI loader and the DDS chip pins.

## Interface
- CH, 2: number of independent channels.
- SYNC_STAGES, 2: input synchroniser depth, ≥1.
- PULSE_W, 4: one-shot pulse width in clk_100M cycles, ≥1.
- HOLDOFF, 8: minimum low cycles after each pulse, ≥0.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max(PULSE_W, HOLDOFF).

Ports:
- clk_100M  in  1  sole clock; all registers update on its falling edge.
- rst  in  1  asynchronous, active-high reset.
- fq_ud  in  CH  per-channel update request (level).
- mode  in  CH  per-channel mode: 0 = level follow, 1 = one-shot.
- clr_ovr  in  CH  per-channel clear for overrun (sampled).
- fq_ud_out  out  CH  strobe to the DDS FQ_UD pin.
- busy  out  CH  1 while the channel FSM is not IDLE.
- overrun  out  CH  sticky; a request was dropped.

## Operation
- Per channel: an SYNC_STAGES-deep flop chain on fq_ud produces s.
  - A registered copy s_d gives rise = s & ~s_d.
  - The chain and edge detector run in both modes.
- Mode 0: fq_ud_out is a register of s.
  - FSM is held in IDLE, pending = 0, busy = 0.
  - overrun holds its value.
- Mode 1 FSM:
  - IDLE: on rise → PULSE, load cnt = PULSE_W−1.
  - PULSE: fq_ud_out = 1. When cnt = 0 → HOLD with cnt = HOLDOFF−1; if HOLDOFF = 0, apply the HOLD exit rule directly.
  - HOLD: fq_ud_out = 0. When cnt = 0 → PULSE if pending (clear pending, reload PULSE_W−1), else → IDLE.
- rise seen in PULSE or HOLD:
  - pending = 0 → set pending.
  - pending = 1 → set overrun; the request is dropped.
- rise on the same cycle HOLD exits: counted as pending and consumed by the same transition. Result is back-to-back PULSE with no IDLE cycle.
- Overrun: set wins over a simultaneous clr_ovr; otherwise clr_ovr = 1 clears it on the next edge.
- Mode change 1→0 mid-pulse: FSM is forced to IDLE and pending is cleared on the next edge. fq_ud_out follows s from that edge.
- Mode change 0→1: no pulse unless a new rise occurs.
- Channels share no state.

## Timing
- Reset (asynchronous, immediate): fq_ud_out = 0, busy = 0, overrun = 0, synchronisers = 0, s_d = 0, FSM = IDLE, cnt = 0, pending = 0.
- Let k be the first falling edge that samples fq_ud = 1.
  - Mode 0: fq_ud_out is high from edge k+SYNC_STAGES. It stays high for exactly as many cycles as fq_ud stayed high.
  - Mode 1: fq_ud_out is high at edges k+SYNC_STAGES … k+SYNC_STAGES+PULSE_W−1.
  - busy rises with fq_ud_out and stays high for PULSE_W+HOLDOFF cycles.
- Minimum pulse period in mode 1 is PULSE_W+HOLDOFF cycles.
- Outputs are glitch-free: each is driven directly from a flop.

## Test plan
- Reset: assert rst during a mode-1 pulse. Required: fq_ud_out, busy and overrun are 0 before the next clock edge, and stay 0 until rst is released.
- Mode 0: fq_ud[0] high for 5 cycles. Required: fq_ud_out[0] high for exactly 5 cycles, starting 2 falling edges after first sampling; busy[0] = 0 throughout.
- Mode 1, single request: fq_ud[1] held high for 20 cycles from edge k. Required: fq_ud_out[1] high at edges k+2..k+5 only; busy[1] high at k+2..k+13; no second pulse.
- Pending: a second rise on ch1 during HOLD. Required: second pulse starts at k+14; overrun = 0. Repeat with the rise on the last HOLD cycle: pulse still starts at k+14.
- Overrun: three rises within one PULSE+HOLD window. Required: exactly two pulses and overrun = 1. Then clr_ovr = 1 on the same edge as a new overrun event: overrun stays 1. clr_ovr alone then clears it.
- Independence and parameter variant: CH=4, HOLDOFF=0, PULSE_W=1 with staggered requests. Required: 1-cycle pulses, back-to-back pulses for queued requests, and no cross-channel effect.

Source files
------------

// File: rtl/fq_ud_pulse_gen.sv
// Multi-channel DDS FQ_UD strobe generator, updating on the falling edge of clk_100M.
// Each channel synchronises its request and either follows the level or emits a fixed-width pulse with hold-off.
module fq_ud_pulse_gen #(
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 4,
    parameter int HOLDOFF     = 8,
    parameter int CNT_W       = 8
) (
    input  logic          clk_100M,
    input  logic          rst,
    input  logic [CH-1:0] fq_ud,
    input  logic [CH-1:0] mode,
    input  logic [CH-1:0] clr_ovr,
    output logic [CH-1:0] fq_ud_out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] overrun
);
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HOLD_SKIP = (HOLDOFF == 0);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        logic                   s_d;
        logic                   rise;
        logic                   pending;
        logic                   out_r;
        logic                   busy_r;
        logic                   ovr_r;
        logic                   exit_now;
        state_t                 state;
        logic [CNT_W-1:0]       cnt;

        assign s    = sync[SYNC_STAGES-1];
        assign rise = s & ~s_d;

        // Last cycle of the pulse+hold window: a queued or coincident request restarts PULSE directly.
        assign exit_now = (cnt == '0) &&
                          ((state == HOLD) || ((state == PULSE) && HOLD_SKIP));

        assign fq_ud_out[g] = out_r;
        assign busy[g]      = busy_r;
        assign overrun[g]   = ovr_r;

        always_ff @(negedge clk_100M or posedge rst) begin
            if (rst) begin
                sync    <= '0;
                s_d     <= 1'b0;
                state   <= IDLE;
                cnt     <= '0;
                pending <= 1'b0;
                out_r   <= 1'b0;
                busy_r  <= 1'b0;
                ovr_r   <= 1'b0;
            end else begin
                sync <= (sync << 1) | SYNC_STAGES'(fq_ud[g]);
                s_d  <= s;
                if (!mode[g]) begin
                    state   <= IDLE;
                    cnt     <= '0;
                    pending <= 1'b0;
                    out_r   <= s;
                    busy_r  <= 1'b0;
                end else begin
                    if (clr_ovr[g]) begin
                        ovr_r <= 1'b0;
                    end
                    // Placed after the clear so a new overrun wins over clr_ovr.
                    if ((state != IDLE) && !exit_now && rise) begin
                        if (pending) begin
                            ovr_r <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                    if (exit_now) begin
                        if (pending | rise) begin
                            state   <= PULSE;
                            cnt     <= PULSE_LD;
                            pending <= pending & rise;
                            out_r   <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            cnt    <= '0;
                            out_r  <= 1'b0;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        case (state)
                            IDLE: begin
                                if (rise) begin
                                    state  <= PULSE;
                                    cnt    <= PULSE_LD;
                                    out_r  <= 1'b1;
                                    busy_r <= 1'b1;
                                end else begin
                                    out_r  <= 1'b0;
                                    busy_r <= 1'b0;
                                end
                            end
                            PULSE: begin
                                busy_r <= 1'b1;
                                if (cnt != '0) begin
                                    cnt   <= cnt - CNT_ONE;
                                    out_r <= 1'b1;
                                end else begin
                                    state <= HOLD;
                                    cnt   <= HOLD_LD;
                                    out_r <= 1'b0;
                                end
                            end
                            HOLD: begin
                                cnt    <= cnt - CNT_ONE;
                                out_r  <= 1'b0;
                                busy_r <= 1'b1;
                            end
                            default: begin
                                state  <= IDLE;
                                cnt    <= '0;
                                out_r  <= 1'b0;
                                busy_r <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fq_ud_pulse_gen.sv
// Bench for fq_ud_pulse_gen: default 2-channel instance plus a 4-channel PULSE_W=1, HOLDOFF=0 variant,
// checked against a window-based reference model and directed timing expectations.
module tb_fq_ud_pulse_gen;
    logic       clk_100M = 1'b1;
    logic       rst      = 1'b1;
    logic [1:0] fq_a     = '0;
    logic [1:0] mode_a   = '0;
    logic [1:0] clr_a    = '0;
    logic [1:0] out_a, busy_a, ovr_a;
    logic [3:0] fq_b     = '0;
    logic [3:0] mode_b   = '0;
    logic [3:0] clr_b    = '0;
    logic [3:0] out_b, busy_b, ovr_b;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_100M = ~clk_100M;

    fq_ud_pulse_gen #(.CH(2), .SYNC_STAGES(2), .PULSE_W(4), .HOLDOFF(8), .CNT_W(8)) dut_a (
        .clk_100M(clk_100M), .rst(rst), .fq_ud(fq_a), .mode(mode_a), .clr_ovr(clr_a),
        .fq_ud_out(out_a), .busy(busy_a), .overrun(ovr_a)
    );

    fq_ud_pulse_gen #(.CH(4), .SYNC_STAGES(2), .PULSE_W(1), .HOLDOFF(0), .CNT_W(8)) dut_b (
        .clk_100M(clk_100M), .rst(rst), .fq_ud(fq_b), .mode(mode_b), .clr_ovr(clr_b),
        .fq_ud_out(out_b), .busy(busy_b), .overrun(ovr_b)
    );

    // Reference: each accepted request opens a window of PULSE_W+HOLDOFF cycles; rem counts down what is left.
    typedef struct {
        int       rem;
        bit       queued;
        bit       ovr;
        bit       out;
        bit       busy;
        bit [7:0] hist;
    } ch_t;

    ch_t ma [2];
    ch_t mb [4];

    function automatic ch_t ch_reset();
        ch_t c;
        c.rem = 0; c.queued = 0; c.ovr = 0; c.out = 0; c.busy = 0; c.hist = '0;
        return c;
    endfunction

    function automatic ch_t step(input ch_t c, input bit d_in, input bit md, input bit clr,
                                 input int ss, input int pw, input int ho);
        bit s, sd, rise;
        int w;
        s    = c.hist[ss-1];
        sd   = c.hist[ss];
        rise = s & !sd;
        w    = pw + ho;
        c.hist = {c.hist[6:0], d_in};
        if (!md) begin
            c.out = s; c.rem = 0; c.queued = 0;
        end else begin
            if (clr) c.ovr = 0;
            if (c.rem == 0) begin
                if (rise) c.rem = w;
            end else if (c.rem == 1) begin
                if (c.queued || rise) begin
                    c.rem = w;
                    c.queued = c.queued && rise;
                end else begin
                    c.rem = 0;
                end
            end else begin
                c.rem--;
                if (rise) begin
                    if (c.queued) c.ovr = 1;
                    else c.queued = 1;
                end
            end
            c.out = (c.rem > ho);
        end
        c.busy = (c.rem > 0);
        return c;
    endfunction

    always @(negedge clk_100M or posedge rst) begin
        if (rst) begin
            foreach (ma[i]) ma[i] = ch_reset();
            foreach (mb[i]) mb[i] = ch_reset();
        end else begin
            foreach (ma[i]) ma[i] = step(ma[i], fq_a[i], mode_a[i], clr_a[i], 2, 4, 8);
            foreach (mb[i]) mb[i] = step(mb[i], fq_b[i], mode_b[i], clr_b[i], 2, 1, 0);
        end
    end

    function automatic logic [5:0] exp_a();
        logic [5:0] v;
        for (int i = 0; i < 2; i++) begin
            v[i] = ma[i].out; v[2+i] = ma[i].busy; v[4+i] = ma[i].ovr;
        end
        return v;
    endfunction

    function automatic logic [11:0] exp_b();
        logic [11:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i] = mb[i].out; v[4+i] = mb[i].busy; v[8+i] = mb[i].ovr;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({ovr_a, busy_a, out_a, ovr_b, busy_b, out_b} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_initial got=%b want=0", {ovr_a, busy_a, out_a, ovr_b, busy_b, out_b});
        end
        rst = 1'b0;
        repeat (3) tick();
        mode_a = 2'b01;
        fq_a   = 2'b01;
        repeat (4) tick();
        vectors++;
        if (out_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prepulse got=%b want=1", out_a[0]);
        end
        fq_a = 2'b00;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({ovr_a, busy_a, out_a} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_async got=%b want=0", {ovr_a, busy_a, out_a});
        end
        for (int t = 0; t < 2; t++) begin
            tick();
            vectors++;
            if ({ovr_a, busy_a, out_a} !== 6'd0) begin
                miscompares++;
                $display("FAIL reset_held t=%0d got=%b want=0", t, {ovr_a, busy_a, out_a});
            end
        end
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            vectors++;
            if ({ovr_a, busy_a, out_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL reset_release t=%0d got=%b want=%b", t, {ovr_a, busy_a, out_a}, exp_a());
            end
        end
    endtask

    task automatic test_mode0();
        mode_a = 2'b00;
        repeat (3) tick();
        for (int t = 0; t < 12; t++) begin
            fq_a[0] = (t < 5);
            tick();
            vectors++;
            if (out_a[0] !== ((t >= 2 && t <= 6) ? 1'b1 : 1'b0) || busy_a[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL mode0_level t=%0d got out=%b busy=%b want out=%b busy=0",
                         t, out_a[0], busy_a[0], (t >= 2 && t <= 6));
            end
            vectors++;
            if ({ovr_a, busy_a, out_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL mode0_model t=%0d got=%b want=%b", t, {ovr_a, busy_a, out_a}, exp_a());
            end
        end
    endtask

    task automatic test_single();
        mode_a = 2'b10;
        repeat (3) tick();
        for (int t = 0; t < 30; t++) begin
            fq_a[1] = (t < 20);
            tick();
            vectors++;
            if (out_a[1] !== ((t >= 2 && t <= 5) ? 1'b1 : 1'b0) ||
                busy_a[1] !== ((t >= 2 && t <= 13) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL single_pulse t=%0d got out=%b busy=%b want out=%b busy=%b",
                         t, out_a[1], busy_a[1], (t >= 2 && t <= 5), (t >= 2 && t <= 13));
            end
            vectors++;
            if ({ovr_a, busy_a, out_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL single_model t=%0d got=%b want=%b", t, {ovr_a, busy_a, out_a}, exp_a());
            end
        end
    endtask

    task automatic test_pending(input int t2);
        for (int t = 0; t < 32; t++) begin
            fq_a[1] = (t < 2) || (t == t2);
            tick();
            vectors++;
            if (out_a[1] !== (((t >= 2 && t <= 5) || (t >= 14 && t <= 17)) ? 1'b1 : 1'b0) ||
                busy_a[1] !== ((t >= 2 && t <= 25) ? 1'b1 : 1'b0) || ovr_a[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL pending_t%0d t=%0d got out=%b busy=%b ovr=%b",
                         t2, t, out_a[1], busy_a[1], ovr_a[1]);
            end
            vectors++;
            if ({ovr_a, busy_a, out_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL pending_model t=%0d got=%b want=%b", t, {ovr_a, busy_a, out_a}, exp_a());
            end
        end
    endtask

    task automatic test_overrun();
        int   pulses;
        logic prev;
        pulses = 0;
        prev   = out_a[1];
        for (int t = 0; t < 30; t++) begin
            fq_a[1] = (t == 0) || (t == 3) || (t == 6);
            tick();
            if (out_a[1] && !prev) pulses++;
            prev = out_a[1];
            vectors++;
            if (ovr_a[1] !== ((t >= 8) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL overrun_set t=%0d got=%b want=%b", t, ovr_a[1], (t >= 8));
            end
            vectors++;
            if ({ovr_a, busy_a, out_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL overrun_model t=%0d got=%b want=%b", t, {ovr_a, busy_a, out_a}, exp_a());
            end
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL overrun_pulses got=%0d want=2", pulses);
        end
        for (int t = 0; t < 30; t++) begin
            fq_a[1]  = (t == 0) || (t == 3) || (t == 6);
            clr_a[1] = (t == 8);
            tick();
            vectors++;
            if (ovr_a[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL overrun_set_wins t=%0d got=%b want=1", t, ovr_a[1]);
            end
        end
        clr_a[1] = 1'b1;
        tick();
        clr_a[1] = 1'b0;
        vectors++;
        if (ovr_a[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear got=%b want=0", ovr_a[1]);
        end
        vectors++;
        if ({ovr_a, busy_a, out_a} !== exp_a()) begin
            miscompares++;
            $display("FAIL overrun_clear_model got=%b want=%b", {ovr_a, busy_a, out_a}, exp_a());
        end
    endtask

    task automatic test_variant();
        logic [15:0] pat [4];
        logic        want;
        pat[0] = 16'h0001;
        pat[1] = 16'h000E;
        pat[2] = 16'h0055;
        pat[3] = 16'h0000;
        mode_b = 4'hF;
        repeat (3) tick();
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) fq_b[i] = pat[i][t];
            tick();
            for (int i = 0; i < 4; i++) begin
                want = (t >= 2) ? pat[i][t-2] : 1'b0;
                if (t >= 3 && pat[i][t-3]) want = 1'b0;
                vectors++;
                if (out_b[i] !== want || busy_b[i] !== want || ovr_b[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL variant_ch%0d t=%0d got out=%b busy=%b ovr=%b want out=%b",
                             i, t, out_b[i], busy_b[i], ovr_b[i], want);
                end
            end
            vectors++;
            if ({ovr_b, busy_b, out_b} !== exp_b()) begin
                miscompares++;
                $display("FAIL variant_model t=%0d got=%b want=%b", t, {ovr_b, busy_b, out_b}, exp_b());
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 2) == 0) fq_a = 2'($urandom);
            if ($urandom_range(0, 2) == 0) fq_b = 4'($urandom);
            if ($urandom_range(0, 40) == 0) mode_a = 2'($urandom);
            if ($urandom_range(0, 40) == 0) mode_b = 4'($urandom);
            clr_a = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            clr_b = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            tick();
            vectors++;
            if ({ovr_a, busy_a, out_a} !== exp_a()) begin
                miscompares++;
                $display("FAIL random_a t=%0d got=%b want=%b", t, {ovr_a, busy_a, out_a}, exp_a());
            end
            vectors++;
            if ({ovr_b, busy_b, out_b} !== exp_b()) begin
                miscompares++;
                $display("FAIL random_b t=%0d got=%b want=%b", t, {ovr_b, busy_b, out_b}, exp_b());
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_single();
        test_pending(8);
        test_pending(12);
        test_overrun();
        test_variant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
